iob_ram_sp_ctrl: RTL

IOB_RAM_SP_CTRL -- requirements
Module: iob_ram_sp_ctrl

---
 rtl/iob_ram_sp_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/iob_ram_sp_ctrl.sv
// Two-port front end for a single-port RAM with registered read data.
// Alternating arbitration and a single outstanding read response with backpressure.
module iob_ram_sp_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              p0_valid_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ready_o,
  output logic              p0_rvalid_o,
  input  logic              p1_valid_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ready_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              rready_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_d_o,
  input  logic [DATA_W-1:0] ram_d_i
);

  // Handshake: a request transfers on a port when valid_i and ready_o are both 1
  // at the rising edge; a response transfers when rvalid_o and rready_i are both 1.
  logic busy_q, busy_d;
  logic owner_q, owner_d;
  logic last_q, last_d;

  logic can_grant;
  logic gnt0, gnt1, accept, rd_accept, sel_we;

  always_comb begin
    can_grant = arst_n_i && (!busy_q || rready_i);
    // Ready never looks at the port's own valid; it only yields to a contending peer.
    p0_ready_o = can_grant && (!p1_valid_i || last_q);
    p1_ready_o = can_grant && (!p0_valid_i || !last_q);
    gnt0 = p0_valid_i && p0_ready_o;
    gnt1 = p1_valid_i && p1_ready_o;
    accept = gnt0 || gnt1;

    sel_we     = gnt1 ? p1_we_i : p0_we_i;
    ram_en_o   = accept;
    ram_we_o   = accept && sel_we;
    ram_addr_o = gnt1 ? p1_addr_i : p0_addr_i;
    ram_d_o    = gnt1 ? p1_wdata_i : p0_wdata_i;
    rd_accept  = accept && !sel_we;

    p0_rvalid_o = busy_q && !owner_q;
    p1_rvalid_o = busy_q && owner_q;
    rdata_o     = ram_d_i;

    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (rd_accept) begin
      busy_d  = 1'b1;
      owner_d = gnt1;
    end else if (busy_q && rready_i) begin
      busy_d = 1'b0;
    end
    if (accept) last_d = gnt1;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule
